// File: rtl/up3_loader.sv
// up3_loader: streams a length-prefixed program image into up3 RAM, holding the CPU in reset until it is loaded.
// Define UP3_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module up3_loader #(
  parameter logic [7:0]  BASE_ADDR  = 8'h00,
  parameter int unsigned RESET_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic       cpu_reset,
  output logic       loading,
  output logic       done,
  output logic [7:0] load_count,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    GET_CSUM,
    DRAIN,
    HOLD,
    RUN,
    ERROR
  } state_t;

  localparam bit HOLD_EN = (RESET_HOLD != 0);
  localparam logic [3:0] HOLD_LAST =
    HOLD_EN ? 4'(RESET_HOLD - 1) : 4'd0;

`ifdef UP3_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam state_t AFTER_LOAD = HOLD_EN ? HOLD : RUN;
  localparam state_t DATA_NX = CSUM_EN ? GET_CSUM : DRAIN;
  localparam state_t LEN0_NX = CSUM_EN ? GET_CSUM : AFTER_LOAD;

  state_t     state;
  state_t     state_nx;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [3:0] hold_q;
  logic       xfer;
  logic       last_byte;
  logic       start_ok;

  assign rx_ready  = (state == GET_LEN) ||
                     (state == GET_DATA) ||
                     (state == GET_CSUM);
  assign xfer      = rx_valid & rx_ready;
  assign last_byte = (idx_q == len_q - 8'd1);
  assign start_ok  = start & ((state == IDLE) ||
                              (state == RUN) ||
                              (state == ERROR));

`ifdef UP3_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  logic       csum_ok;

  assign sum_chk = sum_q + rx_data;
  assign csum_ok = (sum_chk == 8'h00);
  assign err     = (state == ERROR);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cpu_reset = 1'b1;
    loading   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = GET_LEN;
      end
      GET_LEN: begin
        loading = 1'b1;
        if (xfer)
          state_nx = (rx_data == 8'h00) ? LEN0_NX : GET_DATA;
      end
      GET_DATA: begin
        loading = 1'b1;
        if (xfer && last_byte) state_nx = DATA_NX;
      end
      GET_CSUM: begin
        loading = 1'b1;
`ifdef UP3_LOADER_CHECKSUM_EN
        if (xfer) state_nx = csum_ok ? AFTER_LOAD : ERROR;
`else
        state_nx = IDLE;
`endif
      end
      DRAIN: begin
        loading  = 1'b1;
        state_nx = AFTER_LOAD;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_nx = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) state_nx = GET_LEN;
      end
      ERROR: begin
        if (start) state_nx = GET_LEN;
      end
    endcase
  end

  // Write port is registered: a byte taken at edge t is written during t+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= 8'h00;
      idx_q      <= 8'h00;
      hold_q     <= 4'd0;
      load_count <= 8'h00;
      mem_addr   <= BASE_ADDR;
      mem_data   <= 8'h00;
      mem_wren   <= 1'b0;
`ifdef UP3_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      mem_wren <= 1'b0;
      hold_q   <= (state == HOLD) ? hold_q + 4'd1 : 4'd0;
      if (start_ok) load_count <= 8'h00;
      if (xfer && state == GET_LEN) begin
        len_q <= rx_data;
        idx_q <= 8'h00;
`ifdef UP3_LOADER_CHECKSUM_EN
        sum_q <= rx_data;
`endif
      end
      if (xfer && state == GET_DATA) begin
        mem_wren   <= 1'b1;
        mem_addr   <= BASE_ADDR + idx_q;
        mem_data   <= rx_data;
        idx_q      <= idx_q + 8'd1;
        load_count <= load_count + 8'd1;
`ifdef UP3_LOADER_CHECKSUM_EN
        sum_q      <= sum_q + rx_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_up3_loader.sv
// Scoreboard bench for up3_loader: two instances (BASE 00/hold 0, BASE FE/hold 3)
// share one stimulus stream; a monitor pops expected RAM writes per instance.
module tb_up3_loader;

  typedef logic [15:0] wr_t;

  logic       clk = 1'b0;
  logic       reset, start, rx_valid;
  logic [7:0] rx_data;

  logic       rx_ready_a, mem_wren_a, cpu_reset_a;
  logic       loading_a, done_a, err_a;
  logic [7:0] mem_addr_a, mem_data_a, load_count_a;
  logic       rx_ready_b, mem_wren_b, cpu_reset_b;
  logic       loading_b, done_b, err_b;
  logic [7:0] mem_addr_b, mem_data_b, load_count_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_a, last_a, fall_a;
  int first_b, last_b, fall_b;

  wr_t        qa[$];
  wr_t        qb[$];
  logic [7:0] vec[$];

  up3_loader #(.BASE_ADDR(8'h00), .RESET_HOLD(0)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .mem_wren(mem_wren_a),
    .cpu_reset(cpu_reset_a), .loading(loading_a),
    .done(done_a), .load_count(load_count_a), .err(err_a)
  );

  up3_loader #(.BASE_ADDR(8'hFE), .RESET_HOLD(3)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_wren(mem_wren_b),
    .cpu_reset(cpu_reset_b), .loading(loading_b),
    .done(done_b), .load_count(load_count_b), .err(err_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every RAM write against the queues, tracks timing.
  initial begin
    logic prev_a, prev_b;
    wr_t  w;
    prev_a = 1'b1;
    prev_b = 1'b1;
    first_a = -1; last_a = -1; fall_a = -1;
    first_b = -1; last_b = -1; fall_b = -1;
    forever begin
      @(negedge clk);
      if (start) begin
        first_a = -1; last_a = -1; fall_a = -1;
        first_b = -1; last_b = -1; fall_b = -1;
      end
      if (mem_wren_a) begin
        if (first_a < 0) first_a = cyc;
        last_a = cyc;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_a: unexpected write %0h:%0h",
                   mem_addr_a, mem_data_a);
        end else begin
          w = qa.pop_front();
          chk("wr_a", {16'h0, mem_addr_a, mem_data_a}, {16'h0, w});
        end
      end
      if (mem_wren_b) begin
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_b: unexpected write %0h:%0h",
                   mem_addr_b, mem_data_b);
        end else begin
          w = qb.pop_front();
          chk("wr_b", {16'h0, mem_addr_b, mem_data_b}, {16'h0, w});
        end
      end
      if (prev_a && !cpu_reset_a) fall_a = cyc;
      if (prev_b && !cpu_reset_b) fall_b = cyc;
      prev_a = cpu_reset_a;
      prev_b = cpu_reset_b;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready_a && n < 50) begin
      idle(1);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end else begin
      idle(1);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic gap,
                           input logic mid_start,
                           input logic bad);
    logic [7:0] len, ab, s;
    len = 8'(vec.size());
    s   = len;
    for (int i = 0; i < vec.size(); i++) begin
      ab = 8'hFE + 8'(i);
      qa.push_back({8'(i), vec[i]});
      qb.push_back({ab, vec[i]});
      s = s + vec[i];
    end
    pulse_start();
    send(len);
    for (int i = 0; i < vec.size(); i++) begin
      send(vec[i]);
      if (gap) idle(1);
      if (mid_start && i == 1) pulse_start();
    end
`ifdef UP3_LOADER_CHECKSUM_EN
    send(bad ? 8'h01 - s : 8'h00 - s);
`else
    if (bad) idle(1);
    if (s == 8'h00) idle(1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_cpu_reset", cpu_reset_a, 1);
    chk("rst_rx_ready", rx_ready_a, 0);
    chk("rst_wren", mem_wren_a, 0);
    chk("rst_addr_a", mem_addr_a, 8'h00);
    chk("rst_addr_b", mem_addr_b, 8'hFE);
    chk("rst_data", mem_data_a, 0);
    chk("rst_status", {loading_a, done_a, err_a}, 0);
    chk("rst_count", load_count_a, 0);
    reset = 1'b0;
    idle(2);
    chk("idle_status", {cpu_reset_a, rx_ready_a, done_a}, 3'b100);

    // Continuous stream, back-to-back writes.
    vec = '{8'hA1, 8'hB2, 8'hC3};
    run_frame(1'b0, 1'b0, 1'b0);
    idle(8);
    chk("t1_done_a", done_a, 1);
    chk("t1_cpu_reset_a", cpu_reset_a, 0);
    chk("t1_count_a", load_count_a, 3);
    chk("t1_idle_out_a", {loading_a, rx_ready_a, mem_wren_a}, 0);
    chk("t1_fall_a", fall_a - last_a, 1);
    chk("t1_b2b_a", last_a - first_a, 2);
    chk("t1_done_b", done_b, 1);
    chk("t1_count_b", load_count_b, 3);
    chk("t1_hold_b", fall_b - last_b, 4);
    chk("t1_err_a", err_a, 0);

    // Wrap on instance b, data 11,22,33.
    vec = '{8'h11, 8'h22, 8'h33};
    run_frame(1'b0, 1'b0, 1'b0);
    idle(8);
    chk("t2_count_b", load_count_b, 3);
    chk("t2_done_b", done_b, 1);

    // Gapped valid plus ignored start mid-load.
    vec = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(1'b1, 1'b1, 1'b0);
    idle(8);
    chk("t3_count_a", load_count_a, 4);
    chk("t3_count_b", load_count_b, 4);
    chk("t3_done_a", done_a, 1);

    // Reload while running.
    chk("t4_pre_cpu_reset", cpu_reset_a, 0);
    qa.push_back({8'h00, 8'h55});
    qb.push_back({8'hFE, 8'h55});
    pulse_start();
    chk("t4_cpu_reset_a", cpu_reset_a, 1);
    chk("t4_loading_a", {loading_a, done_a}, 2'b10);
    send(8'h01);
    send(8'h55);
`ifdef UP3_LOADER_CHECKSUM_EN
    send(8'hAA);
`endif
    idle(8);
    chk("t4_done_a", done_a, 1);
    chk("t4_count_a", load_count_a, 1);

    // Zero-length image.
    vec = {};
    run_frame(1'b0, 1'b0, 1'b0);
    idle(6);
    chk("t5_done_a", done_a, 1);
    chk("t5_count_a", load_count_a, 0);

`ifdef UP3_LOADER_CHECKSUM_EN
    // 02,10,20,CE passes; 02,10,20,CF fails.
    vec = '{8'h10, 8'h20};
    run_frame(1'b0, 1'b0, 1'b0);
    idle(8);
    chk("cs_pass_done", done_a, 1);
    chk("cs_pass_err", err_a, 0);
    run_frame(1'b0, 1'b0, 1'b1);
    idle(8);
    chk("cs_fail_err_a", err_a, 1);
    chk("cs_fail_err_b", err_b, 1);
    chk("cs_fail_cpu", {cpu_reset_a, done_a, rx_ready_a}, 3'b100);
    pulse_start();
    chk("cs_clear_err", {err_a, loading_a}, 2'b01);
    send(8'h00);
    send(8'h00);
    idle(8);
    chk("cs_recover", done_a, 1);
`endif

    // Reset mid-load after 2 of 5 bytes; the third byte is dropped.
    qa.push_back({8'h00, 8'h01});
    qa.push_back({8'h01, 8'h02});
    qb.push_back({8'hFE, 8'h01});
    qb.push_back({8'hFF, 8'h02});
    pulse_start();
    send(8'h05);
    send(8'h01);
    send(8'h02);
    rx_data  = 8'h03;
    rx_valid = 1'b1;
    reset    = 1'b1;
    idle(1);
    chk("t6_wren", mem_wren_a, 0);
    chk("t6_count", load_count_a, 0);
    chk("t6_cpu_reset", cpu_reset_a, 1);
    chk("t6_state", {loading_a, rx_ready_a, done_a}, 0);
    rx_valid = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(3);
    chk("t6_idle_b", {loading_b, mem_wren_b, cpu_reset_b}, 3'b001);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up3_loader.md
Name: up3_loader

Overview:
- Boot/program loader that sits directly upstream of the 8-bit up3 processor and its RAM.
- Accepts a byte stream (length, payload, optional checksum) over a valid/ready handshake.
- Writes the payload into consecutive RAM locations through the RAM write port (address, data, write-enable).
- Holds the processor in reset while loading and releases it once the last byte is committed.

Parameters:
- BASE_ADDR, 8'h00: RAM address of payload byte 0; address = BASE_ADDR + index, mod 256.
- RESET_HOLD, 0: extra cycles (0..15) cpu_reset stays high after the last write before release.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured in IDLE, RUN or ERROR only.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept; a byte transfers on a clk edge where rx_valid & rx_ready.
- mem_addr  output  8  RAM address, registered.
- mem_data  output  8  RAM write data, registered.
- mem_wren  output  1  RAM write enable, registered, one cycle per payload byte.
- cpu_reset  output  1  processor reset; high except in RUN.
- loading  output  1  high in GET_LEN, GET_DATA, GET_CSUM and DRAIN.
- done  output  1  high in RUN.
- load_count  output  8  payload bytes written since the last start.
- err  output  1  checksum failure; high in ERROR.

Behaviour:
- Reset: state=IDLE; cpu_reset=1; rx_ready=0; mem_wren=0; mem_addr=BASE_ADDR; mem_data=0; load_count=0; loading=0; done=0; err=0. Reset overrides start and any transfer, including mid-load; a partial write in flight is dropped (mem_wren=0 on the next cycle).
- States: IDLE, GET_LEN, GET_DATA, GET_CSUM, DRAIN, HOLD, RUN, ERROR.
- IDLE: rx_ready=0; cpu_reset=1. On start: go to GET_LEN; load_count=0.
- GET_LEN: rx_ready=1. On transfer: latch L=rx_data; index=0.
  - L=0: go to GET_CSUM if CHECKSUM_EN, else HOLD (RESET_HOLD>0) or RUN.
  - L>0: go to GET_DATA.
- GET_DATA: rx_ready=1. On transfer at edge t, during cycle t+1: mem_wren=1, mem_addr=BASE_ADDR+index (8-bit wrap, e.g. BASE 8'hF0, index 8'h20 -> 8'h10), mem_data=byte. On the same edge, index and load_count increment. A transfer on every cycle gives back-to-back writes. After byte L-1, go to GET_CSUM if CHECKSUM_EN, else DRAIN.
- DRAIN: rx_ready=0. The final write occupies this cycle. Next state is HOLD if RESET_HOLD>0, else RUN.
- HOLD: rx_ready=0; counts RESET_HOLD cycles, then RUN.
- RUN: cpu_reset=0; done=1; rx_ready=0. The first RUN cycle is the cycle after the last mem_wren (plus RESET_HOLD). start in RUN: next cycle GET_LEN with cpu_reset=1 (reload while running).
- ERROR: cpu_reset=1; err=1; rx_ready=0. Exits only via start (to GET_LEN, err cleared) or reset.
- start while loading (GET_LEN through HOLD) is ignored.
- rx_valid while rx_ready=0 is not consumed; the source holds it.
- mem_wren=0 in every cycle not directly following a GET_DATA transfer.

Optional Feature:
- Macro: UP3_LOADER_CHECKSUM_EN.
- Defined:
  - GET_CSUM state present, rx_ready=1; its byte is never written to RAM.
  - Running sum S = L + all payload bytes, mod 256. Pass when S + csum_byte = 8'h00.
  - On csum transfer, the last data write (if any) completes in the same cycle.
  - Pass: go to HOLD or RUN. Fail: go to ERROR.
- Not defined: GET_CSUM and ERROR are not reachable; err is tied to 0.

Test Plan:
- Reset, start, stream 03,A1,B2,C3 with BASE_ADDR=0 -> writes (00,A1),(01,B2),(02,C3) on consecutive cycles; cpu_reset falls the cycle after the last wren; load_count=3; done=1.
- BASE_ADDR=8'hFE, stream 03,11,22,33 -> writes at FE, FF, 00 (wrap).
- rx_valid toggled 1/0 every cycle mid-stream, and start pulsed mid-load -> exactly L writes, no duplicate or dropped bytes, start ignored.
- In RUN, pulse start and stream 01,55 -> cpu_reset=1 the cycle after start; write (00,55); RUN re-entered.
- CHECKSUM_EN: stream 02,10,20,CE -> RUN, err=0. Stream 02,10,20,CF -> ERROR, err=1, cpu_reset stays 1; start clears err.
- Assert reset mid-GET_DATA after 2 of 5 bytes -> next cycle IDLE, mem_wren=0, load_count=0, cpu_reset=1; RESET_HOLD=3 run shows 3 extra cpu_reset cycles.
